// File: rtl/eic_defs.sv
// Shared definitions for the external interrupt controller: register map,
// FSM states, CLAIM layout and channel identifiers.
package eic_defs;

  localparam logic [2:0] EIC_OFS_PEND   = 3'd0;
  localparam logic [2:0] EIC_OFS_ENABLE = 3'd1;
  localparam logic [2:0] EIC_OFS_CHSEL  = 3'd2;
  localparam logic [2:0] EIC_OFS_CLAIM  = 3'd3;
  localparam logic [2:0] EIC_OFS_EOI    = 3'd4;
  localparam int unsigned EIC_NUM_REGS  = 5;

  localparam int unsigned EIC_CLAIM_VALID_BIT = 31;

  localparam logic EIC_CH_LO = 1'b0;
  localparam logic EIC_CH_HI = 1'b1;

  typedef enum logic [1:0] {
    EIC_ST_IDLE    = 2'd0,
    EIC_ST_REQ     = 2'd1,
    EIC_ST_SERVICE = 2'd2
  } eic_state_e;

endpackage

// File: rtl/eic_edge_detector.sv
// Two-flop synchronizer plus a third flop for rising-edge detection of one
// asynchronous interrupt line.
module eic_edge_detector (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_src,
  output logic o_edge
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_src;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_edge = r_s2 & ~r_s3;

endmodule

// File: rtl/external_interrupt_controller.sv
// External interrupt controller: edge-latched pending sources, two priority
// channels, memory-mapped control on the core I/O bus.
module external_interrupt_controller #(
  parameter int unsigned NUM_SRC   = 8,
  parameter logic [29:0] BASE_ADDR = 30'h0000_0100
) (
  input  logic               Sys_Clock,
  input  logic               Sys_Reset,
  input  logic [NUM_SRC-1:0] Irq_Src,
  input  logic               IO_EnR,
  input  logic               IO_EnW,
  input  logic [29:0]        IO_Address,
  input  logic [31:0]        IO_DataW,
  output logic [31:0]        IO_DataR,
  output logic               EIC_IntReq,
  output logic               EIC_IntId,
  input  logic               EIC_IntAck
);

  import eic_defs::*;

  logic [NUM_SRC-1:0] w_edge;
  logic [NUM_SRC-1:0] r_pend;
  logic [NUM_SRC-1:0] r_enable;
  logic [NUM_SRC-1:0] r_chsel;
  logic [31:0]        r_data_r;
  eic_state_e         r_state;
  logic               r_int_req;
  logic               r_int_id;
  logic               r_insvc_ch;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    eic_edge_detector u_edge (
      .i_clk  (Sys_Clock),
      .i_rst  (Sys_Reset),
      .i_src  (Irq_Src[g]),
      .o_edge (w_edge[g])
    );
  end

  logic [29:0] w_ofs;
  logic        w_hit;
  logic [2:0]  w_reg;
  logic        w_rd;
  logic        w_wr;
  logic        w_unused;

  assign w_ofs    = IO_Address - BASE_ADDR;
  assign w_hit    = (IO_Address >= BASE_ADDR) && (w_ofs < 30'(EIC_NUM_REGS));
  assign w_reg    = w_ofs[2:0];
  assign w_rd     = IO_EnR & w_hit;
  assign w_wr     = IO_EnW & w_hit;
  assign w_unused = ^{IO_DataW, w_ofs[29:3]};

  logic w_wr_pend;
  logic w_wr_enable;
  logic w_wr_chsel;
  logic w_wr_eoi;

  assign w_wr_pend   = w_wr && (w_reg == EIC_OFS_PEND);
  assign w_wr_enable = w_wr && (w_reg == EIC_OFS_ENABLE);
  assign w_wr_chsel  = w_wr && (w_reg == EIC_OFS_CHSEL);
  assign w_wr_eoi    = w_wr && (w_reg == EIC_OFS_EOI);

  logic [NUM_SRC-1:0] w_act;
  logic               w_cand1;
  logic               w_cand0;
  logic [NUM_SRC-1:0] w_claim_mask;

  assign w_act        = r_pend & r_enable;
  assign w_cand1      = |(w_act & r_chsel);
  assign w_cand0      = |(w_act & ~r_chsel);
  assign w_claim_mask = (r_state == EIC_ST_SERVICE) ?
                        (w_act & ((r_insvc_ch == EIC_CH_HI) ? r_chsel : ~r_chsel)) : '0;

  logic               w_claim_hit;
  logic [4:0]         w_claim_idx;
  logic [NUM_SRC-1:0] w_claim_onehot;

  always_comb begin
    w_claim_hit    = 1'b0;
    w_claim_idx    = '0;
    w_claim_onehot = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (w_claim_mask[i] && !w_claim_hit) begin
        w_claim_hit       = 1'b1;
        w_claim_idx       = i[4:0];
        w_claim_onehot[i] = 1'b1;
      end
    end
  end

  logic w_rd_claim;
  assign w_rd_claim = w_rd && (w_reg == EIC_OFS_CLAIM) && w_claim_hit;

  logic [31:0] w_rdata;

  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      case (w_reg)
        EIC_OFS_PEND:   w_rdata[NUM_SRC-1:0] = r_pend;
        EIC_OFS_ENABLE: w_rdata[NUM_SRC-1:0] = r_enable;
        EIC_OFS_CHSEL:  w_rdata[NUM_SRC-1:0] = r_chsel;
        EIC_OFS_CLAIM: begin
          w_rdata[EIC_CLAIM_VALID_BIT] = w_claim_hit;
          w_rdata[4:0]                 = w_claim_idx;
        end
        default: w_rdata = '0;
      endcase
    end
  end

  // Clear terms are applied before the new edges so a simultaneous set wins.
  logic [NUM_SRC-1:0] w_pend_clr;
  assign w_pend_clr = (w_wr_pend ? IO_DataW[NUM_SRC-1:0] : '0) |
                      (w_rd_claim ? w_claim_onehot : '0);

  always_ff @(posedge Sys_Clock or posedge Sys_Reset) begin
    if (Sys_Reset) begin
      r_pend   <= '0;
      r_enable <= '0;
      r_chsel  <= '0;
      r_data_r <= '0;
    end else begin
      r_pend   <= (r_pend & ~w_pend_clr) | w_edge;
      r_data_r <= w_rdata;
      if (w_wr_enable) r_enable <= IO_DataW[NUM_SRC-1:0];
      if (w_wr_chsel)  r_chsel  <= IO_DataW[NUM_SRC-1:0];
    end
  end

  always_ff @(posedge Sys_Clock or posedge Sys_Reset) begin
    if (Sys_Reset) begin
      r_state    <= EIC_ST_IDLE;
      r_int_req  <= 1'b0;
      r_int_id   <= EIC_CH_LO;
      r_insvc_ch <= EIC_CH_LO;
    end else begin
      case (r_state)
        EIC_ST_IDLE: begin
          if (w_cand1 || w_cand0) begin
            r_state   <= EIC_ST_REQ;
            r_int_req <= 1'b1;
            r_int_id  <= w_cand1 ? EIC_CH_HI : EIC_CH_LO;
          end
        end
        EIC_ST_REQ: begin
          if (EIC_IntAck) begin
            r_state    <= EIC_ST_SERVICE;
            r_int_req  <= 1'b0;
            r_insvc_ch <= r_int_id;
          end
        end
        EIC_ST_SERVICE: begin
          if (w_wr_eoi) begin
            r_state    <= EIC_ST_IDLE;
            r_insvc_ch <= EIC_CH_LO;
          end
        end
        default: begin
          r_state   <= EIC_ST_IDLE;
          r_int_req <= 1'b0;
        end
      endcase
    end
  end

  assign IO_DataR   = r_data_r;
  assign EIC_IntReq = r_int_req;
  assign EIC_IntId  = r_int_id;

endmodule

// File: tb/tb_external_interrupt_controller.sv
// Self-checking bench for external_interrupt_controller: register table plus
// directed interrupt sequences, bus reads checked through a scoreboard queue.
module tb_external_interrupt_controller;

  localparam int unsigned NSRC = 8;
  localparam logic [29:0] BASE = 30'h0000_0100;
  localparam logic [29:0] A_PEND   = BASE + 30'd0;
  localparam logic [29:0] A_ENABLE = BASE + 30'd1;
  localparam logic [29:0] A_CHSEL  = BASE + 30'd2;
  localparam logic [29:0] A_CLAIM  = BASE + 30'd3;
  localparam logic [29:0] A_EOI    = BASE + 30'd4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NSRC-1:0] irq;
  logic            en_r;
  logic            en_w;
  logic [29:0]     addr;
  logic [31:0]     wdata;
  logic [31:0]     rdata;
  logic            int_req;
  logic            int_id;
  logic            int_ack;

  external_interrupt_controller #(
    .NUM_SRC   (NSRC),
    .BASE_ADDR (BASE)
  ) dut (
    .Sys_Clock  (clk),
    .Sys_Reset  (rst),
    .Irq_Src    (irq),
    .IO_EnR     (en_r),
    .IO_EnW     (en_w),
    .IO_Address (addr),
    .IO_DataW   (wdata),
    .IO_DataR   (rdata),
    .EIC_IntReq (int_req),
    .EIC_IntId  (int_id),
    .EIC_IntAck (int_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit          wr;
    logic [29:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t tbl[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  logic rd_d;
  always @(posedge clk or posedge rst) begin
    if (rst) rd_d <= 1'b0;
    else     rd_d <= en_r;
  end

  always @(negedge clk) begin
    if (rd_d) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow: got read data 0x%08h expected no read", rdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk(e.name, rdata, e.exp);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [29:0] a, input logic [31:0] d);
    en_w  = 1'b1;
    addr  = a;
    wdata = d;
    tick(1);
    en_w  = 1'b0;
    wdata = '0;
  endtask

  task automatic rd(input logic [29:0] a, input logic [31:0] exp, input string name);
    exp_t e;
    e.name = name;
    e.exp  = exp;
    sb.push_back(e);
    en_r = 1'b1;
    addr = a;
    tick(1);
    en_r = 1'b0;
  endtask

  task automatic ack();
    int_ack = 1'b1;
    tick(1);
    int_ack = 1'b0;
  endtask

  task automatic chk_req(input string name, input logic req, input logic id);
    chk({name, "_req"}, {31'd0, int_req}, {31'd0, req});
    if (req) chk({name, "_id"}, {31'd0, int_id}, {31'd0, id});
  endtask

  initial begin
    tbl[0]  = '{0, A_PEND,        32'h0,         32'h0,  "rst_pend"};
    tbl[1]  = '{0, A_ENABLE,      32'h0,         32'h0,  "rst_enable"};
    tbl[2]  = '{0, A_CHSEL,       32'h0,         32'h0,  "rst_chsel"};
    tbl[3]  = '{0, A_CLAIM,       32'h0,         32'h0,  "rst_claim"};
    tbl[4]  = '{1, A_ENABLE,      32'hFFFF_FFFF, 32'h0,  ""};
    tbl[5]  = '{0, A_ENABLE,      32'h0,         32'hFF, "enable_mask"};
    tbl[6]  = '{1, A_CHSEL,       32'h1234_56A5, 32'h0,  ""};
    tbl[7]  = '{0, A_CHSEL,       32'h0,         32'hA5, "chsel_rw"};
    tbl[8]  = '{1, BASE + 30'd5,  32'hFFFF_FFFF, 32'h0,  ""};
    tbl[9]  = '{0, BASE + 30'd5,  32'h0,         32'h0,  "ofs5_read"};
    tbl[10] = '{1, BASE - 30'd1,  32'h0000_00FF, 32'h0,  ""};
    tbl[11] = '{0, BASE - 30'd1,  32'h0,         32'h0,  "below_base_read"};
    tbl[12] = '{0, A_EOI,         32'h0,         32'h0,  "eoi_read"};
    tbl[13] = '{0, A_CLAIM,       32'h0,         32'h0,  "claim_idle"};
    tbl[14] = '{1, A_ENABLE,      32'h0,         32'h0,  ""};
    tbl[15] = '{1, A_CHSEL,       32'h0,         32'h0,  ""};
    tbl[16] = '{0, A_ENABLE,      32'h0,         32'h0,  "enable_cleared"};

    rst = 1'b1; irq = '0; en_r = 1'b0; en_w = 1'b0; addr = '0; wdata = '0; int_ack = 1'b0;
    #1;
    chk_req("in_reset", 1'b0, 1'b0);
    chk("in_reset_id", {31'd0, int_id}, 32'd0);
    chk("in_reset_datar", rdata, 32'd0);
    tick(2);
    rst = 1'b0;
    tick(1);

    for (int i = 0; i < 17; i++) begin
      if (tbl[i].wr) wr(tbl[i].addr, tbl[i].data);
      else           rd(tbl[i].addr, tbl[i].exp, tbl[i].name);
    end
    tick(1);
    chk_req("after_table", 1'b0, 1'b0);

    // Single low-priority source
    wr(A_ENABLE, 32'h01);
    wr(A_CHSEL, 32'h00);
    irq[0] = 1'b1;
    tick(1);
    irq[0] = 1'b0;
    tick(1);
    rd(A_PEND, 32'h0, "single_pend_early");
    chk_req("single_pend_visible", 1'b0, 1'b0);
    rd(A_PEND, 32'h01, "single_pend");
    chk_req("single_req", 1'b1, 1'b0);
    tick(2);
    chk_req("single_req_hold", 1'b1, 1'b0);
    ack();
    chk_req("single_after_ack", 1'b0, 1'b0);
    rd(A_CLAIM, 32'h8000_0000, "single_claim");
    rd(A_PEND, 32'h0, "single_pend_claimed");
    wr(A_EOI, 32'h0);
    tick(1);
    chk_req("single_after_eoi", 1'b0, 1'b0);
    rd(A_CLAIM, 32'h0, "single_claim_idle");

    // Two channels raised together: high channel first
    wr(A_ENABLE, 32'hFF);
    wr(A_CHSEL, 32'h80);
    irq[2] = 1'b1;
    irq[7] = 1'b1;
    tick(1);
    irq = '0;
    tick(3);
    chk_req("prio_first", 1'b1, 1'b1);
    ack();
    rd(A_CLAIM, 32'h8000_0007, "prio_claim_hi");
    wr(A_EOI, 32'h0);
    chk_req("prio_at_eoi", 1'b0, 1'b0);
    tick(1);
    chk_req("prio_second", 1'b1, 1'b0);
    ack();
    rd(A_CLAIM, 32'h8000_0002, "prio_claim_lo");
    wr(A_EOI, 32'h0);
    rd(A_PEND, 32'h0, "prio_pend_empty");

    // Request is not withdrawn; claim then finds nothing
    wr(A_CHSEL, 32'h0);
    wr(A_ENABLE, 32'h01);
    irq[0] = 1'b1;
    tick(1);
    irq[0] = 1'b0;
    tick(3);
    chk_req("nowd_req", 1'b1, 1'b0);
    wr(A_ENABLE, 32'h0);
    tick(3);
    chk_req("nowd_hold", 1'b1, 1'b0);
    ack();
    chk_req("nowd_after_ack", 1'b0, 1'b0);
    rd(A_CLAIM, 32'h0, "spurious_claim");
    wr(A_EOI, 32'h0);
    rd(A_PEND, 32'h01, "spurious_pend_kept");
    wr(A_PEND, 32'h01);
    rd(A_PEND, 32'h0, "w1c_clear");
    chk_req("w1c_no_req", 1'b0, 1'b0);

    // W1C in the same cycle as a new edge on the same bit
    irq[3] = 1'b1;
    tick(1);
    irq[3] = 1'b0;
    tick(1);
    wr(A_PEND, 32'h08);
    rd(A_PEND, 32'h08, "collide_set_wins");
    wr(A_PEND, 32'h08);
    rd(A_PEND, 32'h0, "collide_then_clear");

    // Disabled source, stray ack in IDLE
    irq[1] = 1'b1;
    tick(1);
    irq[1] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk_req("disabled_no_req", 1'b0, 1'b0);
    end
    rd(A_PEND, 32'h02, "disabled_pend");
    ack();
    chk_req("stray_ack", 1'b0, 1'b0);
    wr(A_ENABLE, 32'h02);
    chk_req("enable_edge", 1'b0, 1'b0);
    tick(1);
    chk_req("enable_late_req", 1'b1, 1'b0);

    // Asynchronous reset while requesting
    en_r = 1'b1;
    addr = A_ENABLE;
    tick(1);
    en_r = 1'b0;
    chk("pre_reset_datar", rdata, 32'h02);
    rst = 1'b1;
    #1;
    chk_req("async_reset", 1'b0, 1'b0);
    chk("async_reset_datar", rdata, 32'h0);
    tick(2);
    rst = 1'b0;
    tick(1);
    rd(A_PEND, 32'h0, "post_reset_pend");
    rd(A_ENABLE, 32'h0, "post_reset_enable");
    tick(2);
    chk_req("post_reset", 1'b0, 1'b0);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/external_interrupt_controller.md
Name: external_interrupt_controller

Overview:
External interrupt controller (EIC) that sits directly upstream of the core's interrupt port. It drives EIC_IntReq and EIC_IntId into the core and consumes EIC_IntAck from it. It collects up to NUM_SRC asynchronous rising-edge interrupt sources, latches them as pending, and arbitrates between two priority channels. Software controls it through memory-mapped registers on the core I/O bus (IO_EnR/IO_EnW/IO_Address/IO_DataW/IO_DataR).

Parameters:
NUM_SRC, 8, number of interrupt sources (1..31)
BASE_ADDR, 30'h0000_0100, word address of register 0 on the I/O bus

Ports:
Sys_Clock  in  1  system clock, rising-edge
Sys_Reset  in  1  asynchronous, active-high reset
Irq_Src  in  NUM_SRC  raw source lines, asynchronous to Sys_Clock, rising-edge sensitive
IO_EnR  in  1  I/O read strobe from core (MA stage)
IO_EnW  in  1  I/O write strobe from core
IO_Address  in  30  I/O word address
IO_DataW  in  32  I/O write data
IO_DataR  out  32  registered read data; 0 when not selected (OR-able onto shared bus)
EIC_IntReq  out  1  interrupt request to core
EIC_IntId  out  1  requesting channel: 1 = high priority, 0 = low
EIC_IntAck  in  1  single-cycle acknowledge from core

Behaviour:
- Interface: one clock, Sys_Clock; Sys_Reset is asynchronous, active-high. Reset clears all flops: IO_DataR=0, EIC_IntReq=0, EIC_IntId=0, PEND=0, ENABLE=0, CHSEL=0, sync/edge flops=0, in-service=0, state=IDLE.
- Input path per source: 2-flop synchronizer, then a third flop for rising-edge detection (edge = s2 & ~s3).
  - If a source is sampled high at edge k, its PEND bit reads 1 after edge k+2.
- Pending set rule: PEND[i] sets on an edge, regardless of ENABLE. Same-cycle set and W1C clear on the same bit: set wins.
- Register map (word offset from BASE_ADDR); unused bits read 0, writes to them are ignored:
  - 0 PEND: R; write-1-to-clear.
  - 1 ENABLE: RW; per-source enable.
  - 2 CHSEL: RW; 1 = source belongs to channel 1.
  - 3 CLAIM: R only.
    - Bit31 = valid; bits[4:0] = lowest-index pending & enabled source in the in-service channel.
    - A read also clears that source's PEND bit.
    - Returns 0 when there is no in-service channel or no candidate.
  - 4 EOI: W, any data; clears in-service and returns the FSM to IDLE.
  - Offsets 5+ and out-of-range addresses: read 0, writes ignored.
- Read latency: IO_DataR is valid the cycle after IO_EnR (matches synchronous data-memory timing). It is held at 0 in cycles without a selected read.
- Candidates: cand1 = |(PEND & ENABLE & CHSEL); cand0 = |(PEND & ENABLE & ~CHSEL).
- FSM:
  - IDLE: if cand1 or cand0 -> REQ; at that edge EIC_IntReq<=1 and EIC_IntId<=cand1 (channel 1 wins). This is registered, so EIC_IntReq rises the cycle after PEND is visible.
  - REQ: EIC_IntReq and EIC_IntId are held frozen until EIC_IntAck, even if PEND/ENABLE are cleared meanwhile (no withdrawal). On ack -> SERVICE, EIC_IntReq<=0, in-service channel <= EIC_IntId.
  - SERVICE: no new request, no nesting. EOI write -> IDLE. A new request may be raised the cycle after EOI.
- Edge cases:
  - EIC_IntAck in IDLE or SERVICE: ignored.
  - If the claim finds no candidate (spurious interrupt), CLAIM returns valid=0; software must still write EOI.
  - Reset mid-operation: immediate asynchronous return to IDLE, all requests dropped.
  - Bus reads/writes that collide with state transitions: the register write takes effect at the same edge, and the FSM evaluates the pre-write values.

Decomposition:
- Shared package (eic_defs):
  - register offsets EIC_OFS_PEND..EIC_OFS_EOI;
  - FSM state encodings EIC_ST_IDLE/REQ/SERVICE;
  - CLAIM valid-bit position;
  - channel constants EIC_CH_LO/EIC_CH_HI.
- Sub-module eic_edge_detector: the per-source 3-flop synchronizer plus edge detector, instantiated NUM_SRC times via generate.

Test Plan:
- Reset: assert Sys_Reset mid-REQ -> EIC_IntReq=0, PEND=0, IO_DataR=0 immediately; after release, reading ENABLE returns 0.
- Single source: ENABLE=0x01, CHSEL=0; pulse Irq_Src[0] -> PEND reads 0x01, EIC_IntReq=1 and EIC_IntId=0 one cycle after PEND sets; ack -> EIC_IntReq=0; CLAIM reads 0x8000_0000; PEND then reads 0; EOI -> IDLE.
- Priority: ENABLE=0xFF, CHSEL=0x80; Irq_Src[2] and Irq_Src[7] rise in the same cycle -> EIC_IntId=1; CLAIM=0x8000_0007; after EOI, a second request with EIC_IntId=0 and CLAIM=0x8000_0002.
- No withdrawal and spurious claim: in REQ, write ENABLE=0 -> EIC_IntReq stays 1 until ack; CLAIM then reads 0x0000_0000.
- W1C vs set collision: write PEND=0x08 in the same cycle that the source-3 edge is detected -> PEND[3] remains 1.
- Disabled source and stray ack: ENABLE=0 with Irq_Src[1] pulsed -> PEND=0x02, EIC_IntReq never asserts; EIC_IntAck pulsed in IDLE causes no state change.
